// File: rtl/alu_sweep_sequencer_if.sv
// rtl/alu_sweep_sequencer_if.sv - command, ALU drive/sample and result stream bundle for the sweep sequencer
interface alu_sweep_sequencer_if #(
  parameter int SEL_WIDTH = 3
);
  logic                 cmd_valid_in;
  logic                 cmd_ready_out;
  logic [7:0]           cmd_d0_in;
  logic [7:0]           cmd_d1_in;
  logic [7:0]           alu_d0_out;
  logic [7:0]           alu_d1_out;
  logic [SEL_WIDTH-1:0] alu_sel_out;
  logic [15:0]          alu_res_in;
  logic                 alu_gt_in;
  logic                 alu_eq_in;
  logic                 res_valid_out;
  logic                 res_ready_in;
  logic [15:0]          res_data_out;
  logic [SEL_WIDTH-1:0] res_sel_out;
  logic                 res_gt_out;
  logic                 res_eq_out;
  logic                 res_last_out;
  logic                 busy_out;
  logic                 done_out;

  modport master (
    input  cmd_valid_in, cmd_d0_in, cmd_d1_in, alu_res_in, alu_gt_in, alu_eq_in, res_ready_in,
    output cmd_ready_out, alu_d0_out, alu_d1_out, alu_sel_out, res_valid_out, res_data_out,
           res_sel_out, res_gt_out, res_eq_out, res_last_out, busy_out, done_out
  );

  modport slave (
    output cmd_valid_in, cmd_d0_in, cmd_d1_in, alu_res_in, alu_gt_in, alu_eq_in, res_ready_in,
    input  cmd_ready_out, alu_d0_out, alu_d1_out, alu_sel_out, res_valid_out, res_data_out,
           res_sel_out, res_gt_out, res_eq_out, res_last_out, busy_out, done_out
  );
endinterface

// File: rtl/alu_sweep_sequencer.sv
// rtl/alu_sweep_sequencer.sv - steps a combinational ALU through every select code and streams each registered result
module alu_sweep_sequencer #(
  parameter int NUM_OPS   = 8,
  parameter int SEL_WIDTH = 3
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  alu_sweep_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, EMIT} state_t;

  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_OPS - 1);

  state_t               state, state_nxt;
  logic                 accept, handshake, last_beat;
  logic [7:0]           alu_d0, alu_d1;
  logic [SEL_WIDTH-1:0] alu_sel, res_sel;
  logic [15:0]          res_data;
  logic                 res_gt, res_eq, res_last, done;

  always_comb begin
    accept    = bus.cmd_valid_in && (state == IDLE);
    handshake = (state == EMIT) && bus.res_ready_in;
    last_beat = (alu_sel == LAST_SEL);
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   state_nxt = EMIT;
      EMIT:    if (handshake) state_nxt = last_beat ? IDLE : DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // The DRIVE cycle is the ALU settle window; its closing edge samples the result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      alu_d0   <= '0;
      alu_d1   <= '0;
      alu_sel  <= '0;
      res_data <= '0;
      res_sel  <= '0;
      res_gt   <= 1'b0;
      res_eq   <= 1'b0;
      res_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= handshake && last_beat;
      if (accept) begin
        alu_d0  <= bus.cmd_d0_in;
        alu_d1  <= bus.cmd_d1_in;
        alu_sel <= '0;
      end
      if (state == DRIVE) begin
        res_data <= bus.alu_res_in;
        res_gt   <= bus.alu_gt_in;
        res_eq   <= bus.alu_eq_in;
        res_sel  <= alu_sel;
        res_last <= last_beat;
      end
      if (handshake && !last_beat) alu_sel <= alu_sel + SEL_WIDTH'(1);
    end
  end

  assign bus.cmd_ready_out = (state == IDLE);
  assign bus.busy_out      = (state != IDLE);
  assign bus.res_valid_out = (state == EMIT);
  assign bus.alu_d0_out    = alu_d0;
  assign bus.alu_d1_out    = alu_d1;
  assign bus.alu_sel_out   = alu_sel;
  assign bus.res_data_out  = res_data;
  assign bus.res_sel_out   = res_sel;
  assign bus.res_gt_out    = res_gt;
  assign bus.res_eq_out    = res_eq;
  assign bus.res_last_out  = res_last;
  assign bus.done_out      = done;
endmodule

// File: tb/tb_alu_sweep_sequencer.sv
// tb/tb_alu_sweep_sequencer.sv - randomized and directed checks of the sweep sequencer against a beat-list model
module tb_alu_sweep_sequencer;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sweep_sequencer_if #(.SEL_WIDTH(SW)) bus_a ();
  alu_sweep_sequencer_if #(.SEL_WIDTH(SW)) bus_b ();

  alu_sweep_sequencer #(.NUM_OPS(8), .SEL_WIDTH(SW)) dut_a (.clk_in(clk), .rst_n_in(rst_n), .bus(bus_a));
  alu_sweep_sequencer #(.NUM_OPS(4), .SEL_WIDTH(SW)) dut_b (.clk_in(clk), .rst_n_in(rst_n), .bus(bus_b));

  // Stub ALUs: res = {d0,d1} ^ sel, gt = d0 > d1, eq = d0 == d1
  assign bus_a.alu_res_in = {bus_a.alu_d0_out, bus_a.alu_d1_out} ^ 16'(bus_a.alu_sel_out);
  assign bus_a.alu_gt_in  = bus_a.alu_d0_out > bus_a.alu_d1_out;
  assign bus_a.alu_eq_in  = bus_a.alu_d0_out == bus_a.alu_d1_out;
  assign bus_b.alu_res_in = {bus_b.alu_d0_out, bus_b.alu_d1_out} ^ 16'(bus_b.alu_sel_out);
  assign bus_b.alu_gt_in  = bus_b.alu_d0_out > bus_b.alu_d1_out;
  assign bus_b.alu_eq_in  = bus_b.alu_d0_out == bus_b.alu_d1_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0]   data;
    logic [SW-1:0] sel;
    logic          gt;
    logic          eq;
    logic          last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       e, nb;
  logic [7:0]  cur_d0 = '0, cur_d1 = '0;
  logic        done_due = 1'b0;
  int          done_cnt = 0, acc_cnt = 0, done_cyc = 0, acc_cyc = 0, gap = -1, beat_cnt = 0;
  logic [15:0] first_data = '0, last_data = '0;
  logic        first_gt = 1'b0, first_eq = 1'b0;

  // Model: an accepted command expands into the full list of 8 beats; each beat must appear in order,
  // hold while stalled, and done must follow the handshake of the last beat by exactly one cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("done_timing", 32'(bus_a.done_out), 32'(done_due));
      if (bus_a.done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
      done_due = 1'b0;
      chk("busy_vs_model", 32'(bus_a.busy_out), 32'(exp_q.size() != 0));
      chk("ready_vs_model", 32'(bus_a.cmd_ready_out), 32'(exp_q.size() == 0));
      if (bus_a.busy_out) begin
        chk("alu_d0_hold", 32'(bus_a.alu_d0_out), 32'(cur_d0));
        chk("alu_d1_hold", 32'(bus_a.alu_d1_out), 32'(cur_d1));
      end
      if (bus_a.res_valid_out) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          e = exp_q[0];
          chk("res_data", 32'(bus_a.res_data_out), 32'(e.data));
          chk("res_sel", 32'(bus_a.res_sel_out), 32'(e.sel));
          chk("res_gt", 32'(bus_a.res_gt_out), 32'(e.gt));
          chk("res_eq", 32'(bus_a.res_eq_out), 32'(e.eq));
          chk("res_last", 32'(bus_a.res_last_out), 32'(e.last));
          chk("alu_sel_in_emit", 32'(bus_a.alu_sel_out), 32'(e.sel));
          if (bus_a.res_ready_in) begin
            void'(exp_q.pop_front());
            beat_cnt++;
            if (e.sel == '0) begin
              first_data = bus_a.res_data_out;
              first_gt   = bus_a.res_gt_out;
              first_eq   = bus_a.res_eq_out;
            end
            if (e.last) begin
              last_data = bus_a.res_data_out;
              done_due  = 1'b1;
            end
          end
        end
      end
      if (bus_a.cmd_valid_in && bus_a.cmd_ready_out) begin
        acc_cnt++;
        gap     = cyc - done_cyc;
        acc_cyc = cyc;
        cur_d0  = bus_a.cmd_d0_in;
        cur_d1  = bus_a.cmd_d1_in;
        for (int s = 0; s < 8; s++) begin
          nb.data = {cur_d0, cur_d1} ^ 16'(s);
          nb.sel  = SW'(s);
          nb.gt   = cur_d0 > cur_d1;
          nb.eq   = cur_d0 == cur_d1;
          nb.last = (s == 7);
          exp_q.push_back(nb);
        end
      end
    end
  end

  int rmode = 0;
  int stall_left = 0;
  initial begin
    bus_a.res_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: bus_a.res_ready_in = ($urandom_range(0, 2) != 0);
        2: if (bus_a.res_valid_out && bus_a.res_sel_out == SW'(3) && stall_left > 0) begin
             bus_a.res_ready_in = 1'b0;
             stall_left--;
           end else begin
             bus_a.res_ready_in = 1'b1;
           end
        default: bus_a.res_ready_in = 1'b1;
      endcase
    end
  end

  task automatic send_a(input logic [7:0] d0, input logic [7:0] d1);
    int n0;
    int k;
    n0 = acc_cnt;
    k = 0;
    @(posedge clk);
    #1;
    bus_a.cmd_valid_in = 1'b1;
    bus_a.cmd_d0_in = d0;
    bus_a.cmd_d1_in = d1;
    while (acc_cnt == n0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    bus_a.cmd_valid_in = 1'b0;
    if (acc_cnt == n0) chk("accept_timeout", 0, 1);
  endtask

  task automatic run_a(input logic [7:0] d0, input logic [7:0] d1);
    int dn;
    dn = done_cnt;
    send_a(d0, d1);
    for (int k = 0; k < 200 && done_cnt == dn; k++) @(negedge clk);
    if (done_cnt == dn) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int dn, n0, bc, beats, done_at, t0;
    logic [7:0] bd0, bd1;
    bus_a.cmd_valid_in = 1'b0;
    bus_a.cmd_d0_in = '0;
    bus_a.cmd_d1_in = '0;
    bus_b.cmd_valid_in = 1'b0;
    bus_b.cmd_d0_in = '0;
    bus_b.cmd_d1_in = '0;
    bus_b.res_ready_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(bus_a.cmd_ready_out), 1);
    chk("reset_ctrl", 32'({bus_a.busy_out, bus_a.done_out, bus_a.res_valid_out, bus_a.res_last_out,
                           bus_a.res_gt_out, bus_a.res_eq_out, bus_a.res_sel_out, bus_a.alu_sel_out}), 0);
    chk("reset_data", 32'({bus_a.res_data_out, bus_a.alu_d0_out, bus_a.alu_d1_out}), 0);
    rst_n = 1'b1;

    // d0=100, d1=10: first beat 0x640A, last 0x640D, done 17 cycles after accept
    bc = beat_cnt;
    run_a(8'd100, 8'd10);
    chk("pin_latency_17", done_cyc - acc_cyc, 17);
    chk("pin_first_data", 32'(first_data), 32'h640A);
    chk("pin_last_data", 32'(last_data), 32'h640D);
    chk("pin_gt_eq_100_10", 32'({first_gt, first_eq}), 32'b10);
    chk("pin_beat_count", beat_cnt - bc, 8);

    run_a(8'd55, 8'd55);
    chk("pin_gt_eq_55_55", 32'({first_gt, first_eq}), 32'b01);
    run_a(8'd0, 8'd255);
    chk("pin_gt_eq_0_255", 32'({first_gt, first_eq}), 32'b00);
    chk("pin_data_0_255", 32'(first_data), 32'h00FF);

    // 5-cycle stall on sel 3 pushes done out to cycle 22
    rmode = 2;
    stall_left = 5;
    run_a(8'd100, 8'd10);
    chk("pin_latency_22", done_cyc - acc_cyc, 22);
    rmode = 0;

    // Mid-sweep command is ignored, then taken in the done cycle
    dn = done_cnt;
    n0 = acc_cnt;
    send_a(8'h12, 8'h34);
    repeat (4) @(posedge clk);
    #1;
    bus_a.cmd_valid_in = 1'b1;
    bus_a.cmd_d0_in = 8'hAB;
    bus_a.cmd_d1_in = 8'hCD;
    for (int k = 0; k < 100 && acc_cnt < n0 + 2; k++) @(posedge clk);
    #1;
    bus_a.cmd_valid_in = 1'b0;
    chk("b2b_accepted", acc_cnt, n0 + 2);
    chk("b2b_gap", gap, 0);
    for (int k = 0; k < 200 && done_cnt < dn + 2; k++) @(negedge clk);
    chk("b2b_done_count", done_cnt, dn + 2);

    // Reset during the sel 5 beat
    send_a(8'h5A, 8'hC3);
    for (int k = 0; k < 100 && !(bus_a.res_valid_out && bus_a.res_sel_out == SW'(5)); k++) @(negedge clk);
    chk("rst_mid_reached", 32'(bus_a.res_sel_out), 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(bus_a.cmd_ready_out), 1);
    chk("rst_mid_ctrl", 32'({bus_a.busy_out, bus_a.done_out, bus_a.res_valid_out, bus_a.res_last_out,
                             bus_a.res_gt_out, bus_a.res_eq_out, bus_a.res_sel_out, bus_a.alu_sel_out}), 0);
    chk("rst_mid_data", 32'({bus_a.res_data_out, bus_a.alu_d0_out, bus_a.alu_d1_out}), 0);
    exp_q.delete();
    done_due = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_a(8'd200, 8'd3);
    chk("rst_mid_fresh_latency", done_cyc - acc_cyc, 17);

    // Randomized sweeps with random backpressure and stray mid-sweep commands
    rmode = 1;
    for (int r = 0; r < 20; r++) begin
      dn = done_cnt;
      send_a(8'($urandom), 8'($urandom));
      for (int k = 0; k < 400 && done_cnt == dn; k++) begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 2 && $urandom_range(0, 3) == 0) begin
          bus_a.cmd_valid_in = 1'b1;
          bus_a.cmd_d0_in = 8'($urandom);
          bus_a.cmd_d1_in = 8'($urandom);
        end else begin
          bus_a.cmd_valid_in = 1'b0;
        end
      end
      bus_a.cmd_valid_in = 1'b0;
      if (done_cnt == dn) chk("rand_done_timeout", 0, 1);
    end
    rmode = 0;
    chk("model_drained", exp_q.size(), 0);

    // NUM_OPS = 4 instance: 4 beats, last on sel 3, done 9 cycles after accept
    bd0 = 8'($urandom);
    bd1 = 8'($urandom);
    @(posedge clk);
    #1;
    bus_b.cmd_valid_in = 1'b1;
    bus_b.cmd_d0_in = bd0;
    bus_b.cmd_d1_in = bd1;
    @(negedge clk);
    chk("b_ready", 32'(bus_b.cmd_ready_out), 1);
    t0 = cyc;
    @(posedge clk);
    #1;
    bus_b.cmd_valid_in = 1'b0;
    beats = 0;
    done_at = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus_b.res_valid_out) begin
        chk("b_data", 32'(bus_b.res_data_out), 32'({bd0, bd1} ^ 16'(beats)));
        chk("b_sel", 32'(bus_b.res_sel_out), beats);
        chk("b_last", 32'(bus_b.res_last_out), 32'(beats == 3));
        beats++;
      end
      if (bus_b.done_out && done_at < 0) done_at = cyc - t0;
    end
    chk("b_beats", beats, 4);
    chk("b_done_cycle", done_at, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
